// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter that shares one ALU (basic ops plus multi-cycle MUL/DIV)
// between NUM_REQ requesters; one operation in flight, result returned over valid/ready.
module muldiv_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  reset_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [32*NUM_REQ-1:0] req_in1_i,
    input  logic [32*NUM_REQ-1:0] req_in2_i,
    input  logic [3*NUM_REQ-1:0]  req_op_i,
    input  logic [NUM_REQ-1:0]    req_qual_i,
    input  logic [NUM_REQ-1:0]    req_ext_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    input  logic [NUM_REQ-1:0]    rsp_ready_i,
    output logic [31:0]           rsp_data_o,
    output logic                  alu_start_o,
    output logic [31:0]           alu_in1_o,
    output logic [31:0]           alu_in2_o,
    output logic [2:0]            alu_op_o,
    output logic                  alu_qual_o,
    output logic                  alu_ext_o,
    input  logic [31:0]           alu_out_i,
    input  logic                  alu_busy_i
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [IDXW-1:0]     grant_q, grant_d;
    logic [IDXW-1:0]     last_grant_q, last_grant_d;
    logic                alu_start_q, alu_start_d;
    logic [31:0]         alu_in1_q, alu_in1_d;
    logic [31:0]         alu_in2_q, alu_in2_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic                alu_qual_q, alu_qual_d;
    logic                alu_ext_q, alu_ext_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

    logic [IDXW-1:0]     winner;
    logic [IDXW-1:0]     cand;
    logic                any_valid;

    assign any_valid = |req_valid_i;

    // Scan from the farthest candidate down to last_grant+1 so the nearest valid one wins.
    always_comb begin
        winner = last_grant_q;
        cand   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDXW'((int'(last_grant_q) + i) % NUM_REQ);
            if (req_valid_i[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && any_valid) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        alu_start_d  = 1'b0;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_op_d     = alu_op_q;
        alu_qual_d   = alu_qual_q;
        alu_ext_d    = alu_ext_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    alu_in1_d    = req_in1_i[32*winner +: 32];
                    alu_in2_d    = req_in2_i[32*winner +: 32];
                    alu_op_d     = req_op_i[3*winner +: 3];
                    alu_qual_d   = req_qual_i[winner];
                    alu_ext_d    = req_ext_i[winner];
                    grant_d      = winner;
                    last_grant_d = winner;
                    alu_start_d  = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Basic ops never raise busy, so their result is already on alu_out_i here.
                if (!alu_busy_i) begin
                    rsp_data_d           = alu_out_i;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            alu_start_q  <= 1'b0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_op_q     <= '0;
            alu_qual_q   <= 1'b0;
            alu_ext_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            alu_start_q  <= alu_start_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_op_q     <= alu_op_d;
            alu_qual_q   <= alu_qual_d;
            alu_ext_q    <= alu_ext_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_start_o = alu_start_q;
    assign alu_in1_o   = alu_in1_q;
    assign alu_in2_o   = alu_in2_q;
    assign alu_op_o    = alu_op_q;
    assign alu_qual_o  = alu_qual_q;
    assign alu_ext_o   = alu_ext_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_valid_o = rsp_valid_q;

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

- Shares one ALU instance (ADD…AND plus the multi-cycle MUL/DIV extension) between NUM_REQ requesters, e.g. two hart pipelines or a CPU plus a coprocessor.
- Arbitrates round-robin, latches the winner's operands and drives the ALU's start/operand inputs.
- Waits on the ALU busy flag, then returns the result to the winner over a valid/ready response channel.
- Sits between the requesters' execute stages and a single `alu`. It is the only driver of that ALU's inputs.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8); IDXW = max(1, $clog2(NUM_REQ))

Ports:
- clk  in  1  system clock, rising edge
- reset_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  request k valid; held until accepted
- req_ready_o  out  NUM_REQ  one-hot (or zero) acceptance strobe
- req_in1_i  in  32*NUM_REQ  operand 1; requester k uses bits [32k+31:32k]
- req_in2_i  in  32*NUM_REQ  operand 2, same packing
- req_op_i  in  3*NUM_REQ  ALU op code, same packing
- req_qual_i  in  NUM_REQ  op qualifier (+/-, logical/arithmetic)
- req_ext_i  in  NUM_REQ  1 = MUL/DIV extension op
- rsp_valid_o  out  NUM_REQ  one-hot response valid to the granted requester
- rsp_ready_i  in  NUM_REQ  response accepted by requester k
- rsp_data_o  out  32  result, shared; valid for the requester whose rsp_valid_o bit is set
- alu_start_o  out  1  one-cycle start pulse to ALU
- alu_in1_o, alu_in2_o  out  32  latched operands, stable from ISSUE until return to IDLE
- alu_op_o  out  3  latched op
- alu_qual_o, alu_ext_o  out  1  latched qualifier / extension
- alu_out_i  in  32  ALU result
- alu_busy_i  in  1  ALU busy (high while MUL/DIV in progress)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid_i is set, select the winner round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ.
  - req_ready_o[winner] is asserted combinationally in the same cycle.
  - On that edge: latch operands, op, qual and ext into the alu_* registers; set grant = winner and last_grant = winner; go to ISSUE.
  - No valid request: req_ready_o = 0, stay in IDLE.
- **ISSUE**: alu_start_o = 1 for exactly this cycle; go to WAIT.
- **WAIT**
  - If alu_busy_i = 0, capture alu_out_i into rsp_data_o and go to RESP.
  - Otherwise stay in WAIT.
  - This rule covers both cases:
    - Basic op: busy never rises, result is ready the cycle after the start pulse.
    - MUL/DIV: busy rises on the start edge and the result is valid when busy falls.
- **RESP**
  - rsp_valid_o[grant] = 1, held with rsp_data_o stable until rsp_ready_i[grant] = 1.
  - Then go to IDLE.
  - rsp_ready_i bits of non-granted requesters are ignored.
- req_ready_o is 0 in every state except IDLE. Only one operation is in flight at a time.
- A requester may re-request in the same cycle its response completes. Its request is considered in the next IDLE cycle at the lowest round-robin priority.
- The WAIT state has no timeout; the ALU is trusted to finish. Divide-by-zero produces whatever result the ALU produces.
- Reset values:
  - State: IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - grant = 0.
  - All alu_*_o, rsp_data_o, rsp_valid_o, req_ready_o and alu_start_o: 0.
- Reset asserted mid-operation clears the block to IDLE immediately and drops any pending response. The ALU is reset by the same system reset.

## Timing
- Accept at cycle 0 (ready & valid), start pulse at cycle 1, WAIT first evaluated at cycle 2.
- Basic op: rsp_valid_o is high from cycle 3. Minimum turnaround is 4 cycles if rsp_ready_i is already high, after which IDLE accepts again.
- MUL/DIV: rsp_valid_o is high one cycle after the first WAIT cycle with alu_busy_i = 0.
- alu_start_o is never high in two consecutive cycles, and never high while alu_busy_i = 1.
- All outputs are registered except req_ready_o, which is combinational from req_valid_i and state.

## Test plan
- **Single basic op:** requester 0 issues ADD with in1=5, in2=7, qual=0. Required: start pulse at cycle 1, rsp_data_o=12, rsp_valid_o=01 at cycle 3, ALU released at cycle 4.
- **Round-robin:** NUM_REQ=2, both requesters hold valid continuously.
  - Grants alternate 0,1,0,1.
  - Requester 1 issues SUB with 3-5 and receives 0xFFFFFFFE.
  - Requester 0 issues SLTU with 3,5 and receives 1.
- **MUL through the ALU:** requester 1 issues ext=1, op=000, 0x10000 * 0x10.
  - Required: rsp_data_o = 0x00100000, and no rsp_valid_o while alu_busy_i is high.
  - req_ready_o[0] stays 0 for the whole operation even with req_valid_i[0]=1.
- **Response backpressure:** hold rsp_ready_i low for 5 cycles on DIV 100/7.
  - Required: rsp_valid_o and rsp_data_o = 14 stable for all 5 cycles, and no new acceptance until the handshake completes.
- **Reset mid-operation:** assert reset_ni low during WAIT of a DIV. Required:
  - All outputs go to 0 asynchronously.
  - After release, requester 0 wins first.
  - A new ADD 1+1 returns 2.
- **NUM_REQ=3 wrap:** only requesters 2 and 0 are valid, last_grant=1. Required: grant order is 2 then 0.
